instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have parameter TRAP_PC, default 32'h0000_0080, the redirect target for an unsupported opcode.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with the ports listed below.
- clock__i  in  1  clock; all state updates on its rising edge.
- reset__i  in  1  synchronous, active-high reset.
- imem_req__o  out  1  instruction-memory request, held until acknowledged.
- imem_addr__o  out  32  word address of the request.
- imem_ack__i  in  1  request accepted; imem_data__i is valid in the same cycle.
- imem_data__i  in  32  instruction word.
- redirect__i  in  1  taken branch or jump from a later stage.
- redirect_pc__i  in  32  redirect target.
- stall__i  in  1  decode cannot accept; hold the output.
- instr__o  out  32  instruction to decode; bits [31:26] feed the control decoder opcode.
- pc_plus4__o  out  32  PC of instr__o plus 4.
- valid__o  out  1  instr__o is meaningful.
- trap__o  out  1  one-cycle pulse: unsupported opcode fetched.
- trap_epc__o  out  32  PC of the offending instruction, held until the next trap.

Function
REQ-004 The block SHALL allow at most one outstanding request; imem_addr__o SHALL be stable while imem_req__o=1 and imem_ack__i=0.
REQ-005 The FSM SHALL have three states: FETCH (request issued), HOLD (skid entry full, no request), DROP (request outstanding whose data must be discarded).
REQ-006 In FETCH, ack with no redirect SHALL load the word into the output register if the output is free (valid__o=0 or stall__i=0), and SHALL increment the PC by 4.
REQ-007 In FETCH, ack while valid__o=1 and stall__i=1 SHALL store the word in the skid entry and move to HOLD with imem_req__o=0.
REQ-008 In HOLD, the first cycle with stall__i=0 SHALL move the skid entry to the output and return to FETCH.
REQ-009 Minimum latency SHALL be one cycle: data acknowledged in cycle N appears on instr__o with valid__o=1 in cycle N+1.
REQ-010 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 -> 0).
REQ-011 redirect__i SHALL have highest priority over ack, stall and trap, and SHALL clear valid__o and the skid entry on the next cycle.
REQ-012 On redirect, the PC SHALL load redirect_pc__i with bits [1:0] forced to 0.
REQ-013 A redirect while a request is outstanding without ack SHALL move the FSM to DROP; DROP SHALL keep the old request until ack, discard that data, then go to FETCH at the new PC.
REQ-014 A redirect in the same cycle as ack SHALL discard the data and go directly to FETCH at the new PC.
REQ-015 While stall__i=1 and valid__o=1, instr__o and pc_plus4__o SHALL hold their values.

Reset
REQ-016 Reset SHALL set PC=RESET_PC, state=FETCH, valid__o=0, skid empty, trap__o=0, trap_epc__o=0, instr__o=0, pc_plus4__o=0.
REQ-017 imem_req__o SHALL be 0 during reset and 1 (address RESET_PC) in the first cycle after reset deasserts.
REQ-018 Reset SHALL override any in-flight request; an ack arriving during reset SHALL be ignored.

Configuration
REQ-019 With INSTR_FETCH_TRAP_EN defined, an acknowledged word whose opcode is not in {000000, 001000, 001100, 001101, 001110, 101011, 100011, 000100} SHALL NOT be forwarded.
- The PC SHALL load TRAP_PC.
- trap__o SHALL pulse for one cycle.
- trap_epc__o SHALL capture the offending PC.
- If the same ack coincides with redirect__i, the redirect SHALL win and no trap SHALL be raised.
REQ-020 Without INSTR_FETCH_TRAP_EN, all words SHALL be forwarded unchanged; trap__o and trap_epc__o SHALL exist and be tied to 0.

Structure
REQ-021 Package cpu_pkg SHALL hold the opcode constants, the fetch FSM state enum, and the default RESET_PC and TRAP_PC values.
REQ-022 The one-entry skid buffer SHALL be a sub-module named instr_fetch_skid.

Verification
REQ-023 Reset, then ack every cycle with words 0x20010001, 0x20020002 -> addresses 0x0, 0x4, 0x8; instr__o valid one cycle after each ack; pc_plus4__o = 0x4, 0x8.
REQ-024 stall__i=1 for 3 cycles with a request outstanding and acked -> skid holds the word, imem_req__o=0, output unchanged; after release, words appear in order with none lost or duplicated.
REQ-025 redirect__i=1 with redirect_pc__i=0x103 while a request to 0x8 is unacked; ack 2 cycles later -> data discarded, next request address 0x100, valid__o=0 until the new word arrives.
REQ-026 Redirect to 0xFFFFFFFC, ack -> next request address 0x00000000.
REQ-027 With INSTR_FETCH_TRAP_EN, opcode 111111 fetched at 0x10 -> trap__o pulse, trap_epc__o=0x10, next address 0x80, valid__o stays 0.
REQ-028 Without INSTR_FETCH_TRAP_EN, opcode 111111 fetched at 0x10 -> word forwarded, trap__o=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, fetch FSM states and
// default fetch addresses.
package cpu_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_PC  = 32'h0000_0080;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI,
            OP_XORI, OP_SW, OP_LW, OP_BEQ: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_fetch_skid.sv
// One-entry skid buffer catching a fetched word while decode is stalled.
// Clear takes priority over load.
module instr_fetch_skid (
    input  logic        clock__i,
    input  logic        reset__i,
    input  logic        load__i,
    input  logic        clear__i,
    input  logic [31:0] instr__i,
    input  logic [31:0] pc_plus4__i,
    output logic        valid__o,
    output logic [31:0] instr__o,
    output logic [31:0] pc_plus4__o
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;

    // Next-state for the entry: capture on load, empty on clear.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (load__i) begin
            valid_d = 1'b1;
            instr_d = instr__i;
            pc4_d   = pc_plus4__i;
        end
        if (clear__i) begin
            valid_d = 1'b0;
        end
    end

    // Entry registers.
    always_ff @(posedge clock__i) begin
        if (reset__i) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid__o    = valid_q;
    assign instr__o    = instr_q;
    assign pc_plus4__o = pc4_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: single outstanding imem request, skid on stall,
// redirect with drop state. Optional opcode trap: INSTR_FETCH_TRAP_EN.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] TRAP_PC  = DEF_TRAP_PC
) (
    input  logic        clock__i,
    input  logic        reset__i,
    output logic        imem_req__o,
    output logic [31:0] imem_addr__o,
    input  logic        imem_ack__i,
    input  logic [31:0] imem_data__i,
    input  logic        redirect__i,
    input  logic [31:0] redirect_pc__i,
    input  logic        stall__i,
    output logic [31:0] instr__o,
    output logic [31:0] pc_plus4__o,
    output logic        valid__o,
    output logic        trap__o,
    output logic [31:0] trap_epc__o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  drop_pc_q, drop_pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;
    logic         trap_q, trap_d;
    logic [31:0]  epc_q, epc_d;

    logic         skid_load, skid_clear, skid_valid;
    logic [31:0]  skid_instr, skid_pc4;
    logic         out_free, bad_op;
    logic [31:0]  ack_pc4, tgt_pc;

`ifdef INSTR_FETCH_TRAP_EN
    assign bad_op = !op_supported(imem_data__i[31:26]);
`else
    assign bad_op = 1'b0;
`endif

    assign out_free = !valid_q || !stall__i;
    assign ack_pc4  = pc_q + 32'd4;
    assign tgt_pc   = {redirect_pc__i[31:2], 2'b00};

    instr_fetch_skid u_skid (
        .clock__i    (clock__i),
        .reset__i    (reset__i),
        .load__i     (skid_load),
        .clear__i    (skid_clear),
        .instr__i    (imem_data__i),
        .pc_plus4__i (ack_pc4),
        .valid__o    (skid_valid),
        .instr__o    (skid_instr),
        .pc_plus4__o (skid_pc4)
    );

    // Next-state and datapath; redirect overrides everything else.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_pc_d  = drop_pc_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        trap_d     = 1'b0;
        epc_d      = epc_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (out_free) begin
            valid_d = 1'b0;
        end
        if (redirect__i) begin
            valid_d    = 1'b0;
            skid_clear = 1'b1;
            if (state_q == HOLD || imem_ack__i) begin
                state_d = FETCH;
                pc_d    = tgt_pc;
            end else begin
                state_d   = DROP;
                drop_pc_d = tgt_pc;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_ack__i) begin
                        if (bad_op) begin
                            pc_d   = TRAP_PC;
                            trap_d = 1'b1;
                            epc_d  = pc_q;
                        end else begin
                            pc_d = ack_pc4;
                            if (out_free) begin
                                instr_d = imem_data__i;
                                pc4_d   = ack_pc4;
                                valid_d = 1'b1;
                            end else begin
                                skid_load = 1'b1;
                                state_d   = HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!stall__i && skid_valid) begin
                        instr_d    = skid_instr;
                        pc4_d      = skid_pc4;
                        valid_d    = 1'b1;
                        skid_clear = 1'b1;
                        state_d    = FETCH;
                    end
                end
                DROP: begin
                    if (imem_ack__i) begin
                        pc_d    = drop_pc_q;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock__i) begin
        if (reset__i) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            drop_pc_q <= RESET_PC;
            instr_q   <= '0;
            pc4_q     <= '0;
            valid_q   <= 1'b0;
            trap_q    <= 1'b0;
            epc_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_pc_q <= drop_pc_d;
            instr_q   <= instr_d;
            pc4_q     <= pc4_d;
            valid_q   <= valid_d;
            trap_q    <= trap_d;
            epc_q     <= epc_d;
        end
    end

    assign imem_req__o  = !reset__i && (state_q != HOLD);
    assign imem_addr__o = pc_q;
    assign instr__o     = instr_q;
    assign pc_plus4__o  = pc4_q;
    assign valid__o     = valid_q;
    assign trap__o      = trap_q;
    assign trap_epc__o  = epc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, streaming, stall/skid,
// redirect/drop, PC wrap and unsupported-opcode handling.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;
    logic        redir;
    logic [31:0] redir_pc;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        trap;
    logic [31:0] epc;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clock__i       (clk),
        .reset__i       (rst),
        .imem_req__o    (req),
        .imem_addr__o   (addr),
        .imem_ack__i    (ack),
        .imem_data__i   (data),
        .redirect__i    (redir),
        .redirect_pc__i (redir_pc),
        .stall__i       (stall),
        .instr__o       (instr),
        .pc_plus4__o    (pc4),
        .valid__o       (valid),
        .trap__o        (trap),
        .trap_epc__o    (epc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ack = 1'b1; data = 32'h2001_0001;
        redir = 1'b0; redir_pc = '0; stall = 1'b0;
        step();
        step();
        n_chk++;
        if (req !== 1'b0) begin
            n_fail++; $display("FAIL rst_req got %0h want 0", req);
        end
        n_chk++;
        if (valid !== 1'b0 || instr !== 32'h0 || pc4 !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_out got v=%0h i=%h p=%h want 0/0/0",
                     valid, instr, pc4);
        end
        n_chk++;
        if (trap !== 1'b0 || epc !== 32'h0) begin
            n_fail++; $display("FAIL rst_trap got %0h/%h want 0/0", trap, epc);
        end
        rst = 1'b0; ack = 1'b0;
        #1;
        n_chk++;
        if (req !== 1'b1 || addr !== 32'h0) begin
            n_fail++; $display("FAIL post_rst_req got %0h@%h want 1@0", req, addr);
        end
    endtask

    task automatic test_stream();
        ack = 1'b1; data = 32'h2001_0001;
        step();
        n_chk++;
        if (valid !== 1'b1 || instr !== 32'h2001_0001 || pc4 !== 32'h4) begin
            n_fail++;
            $display("FAIL stream0 got v=%0h i=%h p=%h want 1/20010001/4",
                     valid, instr, pc4);
        end
        n_chk++;
        if (addr !== 32'h4) begin
            n_fail++; $display("FAIL stream0_addr got %h want 4", addr);
        end
        data = 32'h2002_0002;
        step();
        n_chk++;
        if (valid !== 1'b1 || instr !== 32'h2002_0002 || pc4 !== 32'h8) begin
            n_fail++;
            $display("FAIL stream1 got v=%0h i=%h p=%h want 1/20020002/8",
                     valid, instr, pc4);
        end
        ack = 1'b0;
        step();
        n_chk++;
        if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h8) begin
            n_fail++;
            $display("FAIL stream_idle got v=%0h r=%0h a=%h want 0/1/8",
                     valid, req, addr);
        end
    endtask

    task automatic test_stall();
        ack = 1'b1; data = 32'h2003_0003;
        step();
        stall = 1'b1; data = 32'h2004_0004;
        step();
        ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (req !== 1'b0 || valid !== 1'b1 ||
                instr !== 32'h2003_0003 || pc4 !== 32'hC) begin
                n_fail++;
                $display("FAIL stall_hold%0d got r=%0h v=%0h i=%h p=%h want 0/1/20030003/c",
                         i, req, valid, instr, pc4);
            end
            if (i < 2) step();
        end
        stall = 1'b0;
        step();
        n_chk++;
        if (valid !== 1'b1 || instr !== 32'h2004_0004 || pc4 !== 32'h10) begin
            n_fail++;
            $display("FAIL stall_release got v=%0h i=%h p=%h want 1/20040004/10",
                     valid, instr, pc4);
        end
        n_chk++;
        if (req !== 1'b1 || addr !== 32'h10) begin
            n_fail++; $display("FAIL stall_req got %0h@%h want 1@10", req, addr);
        end
        ack = 1'b1; data = 32'h2005_0005;
        step();
        ack = 1'b0;
        n_chk++;
        if (valid !== 1'b1 || instr !== 32'h2005_0005 || pc4 !== 32'h14) begin
            n_fail++;
            $display("FAIL stall_next got v=%0h i=%h p=%h want 1/20050005/14",
                     valid, instr, pc4);
        end
        step();
    endtask

    task automatic test_redirect();
        redir = 1'b1; redir_pc = 32'h8; ack = 1'b1; data = 32'hDEAD_BEEF;
        step();
        n_chk++;
        if (valid !== 1'b0 || addr !== 32'h8 || req !== 1'b1) begin
            n_fail++;
            $display("FAIL redir_ack got v=%0h r=%0h a=%h want 0/1/8",
                     valid, req, addr);
        end
        redir_pc = 32'h103; ack = 1'b0;
        step();
        redir = 1'b0;
        n_chk++;
        if (req !== 1'b1 || addr !== 32'h8 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop0 got r=%0h a=%h v=%0h want 1/8/0",
                     req, addr, valid);
        end
        step();
        n_chk++;
        if (addr !== 32'h8 || valid !== 1'b0) begin
            n_fail++; $display("FAIL drop1 got a=%h v=%0h want 8/0", addr, valid);
        end
        ack = 1'b1; data = 32'h2009_0009;
        step();
        n_chk++;
        if (addr !== 32'h100 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_done got a=%h v=%0h want 100/0", addr, valid);
        end
        data = 32'h2006_0006;
        step();
        ack = 1'b0;
        n_chk++;
        if (valid !== 1'b1 || instr !== 32'h2006_0006 || pc4 !== 32'h104) begin
            n_fail++;
            $display("FAIL redir_new got v=%0h i=%h p=%h want 1/20060006/104",
                     valid, instr, pc4);
        end
    endtask

    task automatic test_wrap();
        redir = 1'b1; redir_pc = 32'hFFFF_FFFC; ack = 1'b1;
        step();
        redir = 1'b0;
        n_chk++;
        if (addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_tgt got %h want fffffffc", addr);
        end
        data = 32'h2007_0007;
        step();
        ack = 1'b0;
        n_chk++;
        if (addr !== 32'h0 || pc4 !== 32'h0 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap got a=%h p=%h v=%0h want 0/0/1",
                     addr, pc4, valid);
        end
    endtask

    task automatic test_bad_opcode();
        redir = 1'b1; redir_pc = 32'h10; ack = 1'b1;
        step();
        redir = 1'b0; data = 32'hFC00_0000;
        step();
        ack = 1'b0;
`ifdef INSTR_FETCH_TRAP_EN
        n_chk++;
        if (trap !== 1'b1 || epc !== 32'h10) begin
            n_fail++; $display("FAIL trap got %0h/%h want 1/10", trap, epc);
        end
        n_chk++;
        if (addr !== 32'h80 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL trap_pc got a=%h v=%0h want 80/0", addr, valid);
        end
        step();
        n_chk++;
        if (trap !== 1'b0 || epc !== 32'h10 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL trap_pulse got t=%0h e=%h v=%0h want 0/10/0",
                     trap, epc, valid);
        end
`else
        n_chk++;
        if (valid !== 1'b1 || instr !== 32'hFC00_0000 || pc4 !== 32'h14) begin
            n_fail++;
            $display("FAIL fwd got v=%0h i=%h p=%h want 1/fc000000/14",
                     valid, instr, pc4);
        end
        n_chk++;
        if (trap !== 1'b0 || epc !== 32'h0 || addr !== 32'h14) begin
            n_fail++;
            $display("FAIL no_trap got t=%0h e=%h a=%h want 0/0/14",
                     trap, epc, addr);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_bad_opcode();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
